// File: rtl/mvb_split_m_to_n.sv
// MVB M-to-N splitter: buffers one wide RX word and drains its valid
// items, packed to the low lanes, over as many narrow TX words as needed.
module mvb_split_m_to_n #(
   parameter int INPUTS     = 16,
   parameter int OUTPUTS    = 4,
   parameter int DATA_WIDTH = 77
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic [INPUTS*DATA_WIDTH-1:0]  RX_DATA,
   input  logic [INPUTS-1:0]             RX_VLD,
   input  logic                          RX_SRC_RDY,
   output logic                          RX_DST_RDY,
   output logic [OUTPUTS*DATA_WIDTH-1:0] TX_DATA,
   output logic [OUTPUTS-1:0]            TX_VLD,
   output logic                          TX_SRC_RDY,
   input  logic                          TX_DST_RDY
);

   localparam int CW = $clog2(INPUTS + 1);
   localparam logic [CW-1:0] LP_OUTS = CW'(OUTPUTS);

   logic [INPUTS*DATA_WIDTH-1:0]  r_buf_data;
   logic [INPUTS-1:0]             r_buf_rem;
   logic [OUTPUTS*DATA_WIDTH-1:0] r_tx_data;
   logic [OUTPUTS-1:0]            r_tx_vld;
   logic                          r_tx_src_rdy;

   logic [CW-1:0]                 w_pos [INPUTS];
   logic [CW-1:0]                 w_cnt;
   logic [OUTPUTS*DATA_WIDTH-1:0] w_sel_data;
   logic [OUTPUTS-1:0]            w_sel_vld;
   logic [INPUTS-1:0]             w_rem_next;
   logic                          w_out_en;
   logic                          w_last;
   logic                          w_rx_acc;
   logic                          w_has_items;

   // w_pos[i] = number of pending lanes below lane i = its TX slot
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < INPUTS; i++) begin
         w_pos[i] = w_cnt;
         w_cnt    = w_cnt + CW'(r_buf_rem[i]);
      end
   end

   always_comb begin
      w_sel_data = '0;
      w_sel_vld  = '0;
      w_rem_next = r_buf_rem;
      for (int j = 0; j < OUTPUTS; j++) begin
         for (int i = 0; i < INPUTS; i++) begin
            if (r_buf_rem[i] && (w_pos[i] == CW'(j))) begin
               w_sel_data[j*DATA_WIDTH +: DATA_WIDTH] =
                  r_buf_data[i*DATA_WIDTH +: DATA_WIDTH];
               w_sel_vld[j]  = 1'b1;
               w_rem_next[i] = 1'b0;
            end
         end
      end
   end

   assign w_has_items = |r_buf_rem;
   assign w_out_en    = !r_tx_src_rdy || TX_DST_RDY;
   assign w_last      = w_out_en && (w_cnt <= LP_OUTS);
   assign RX_DST_RDY  = RESET_N && w_last;
   assign w_rx_acc    = RX_SRC_RDY && RX_DST_RDY;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_buf_rem    <= '0;
         r_tx_vld     <= '0;
         r_tx_src_rdy <= 1'b0;
      end else begin
         if (w_out_en) begin
            r_tx_src_rdy <= w_has_items;
            r_tx_vld     <= w_has_items ? w_sel_vld : '0;
         end
         // a new word replaces the buffer as its last chunk leaves
         if (w_rx_acc) begin
            r_buf_rem <= RX_VLD;
         end else if (w_out_en) begin
            r_buf_rem <= w_rem_next;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_rx_acc) begin
         r_buf_data <= RX_DATA;
      end
      if (w_out_en && w_has_items) begin
         r_tx_data <= w_sel_data;
      end
   end

   assign TX_DATA    = r_tx_data;
   assign TX_VLD     = r_tx_vld;
   assign TX_SRC_RDY = r_tx_src_rdy;

endmodule

// File: tb/tb_mvb_split_m_to_n.sv
// Bench for mvb_split_m_to_n: directed vectors plus a random stream,
// with a negedge monitor that checks TX ordering and stall stability.
module tb_mvb_split_m_to_n;

   localparam int IN  = 16;
   localparam int OUT = 4;
   localparam int DW  = 77;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [IN*DW-1:0]  rx_data = '0;
   logic [IN-1:0]     rx_vld = '0;
   logic              rx_src = 1'b0;
   logic              rx_dst;
   logic [OUT*DW-1:0] tx_data;
   logic [OUT-1:0]    tx_vld;
   logic              tx_src;
   logic              tx_dst;
   logic              dst_fix = 1'b1;
   logic              rnd_dst = 1'b0;
   logic              dst_rnd = 1'b1;

   int checks = 0;
   int failures = 0;
   int tx_words = 0;

   logic [DW-1:0]     exp_q [$];
   logic [OUT-1:0]    vlog [$];
   logic [OUT*DW-1:0] dlog [$];

   always #5 clk = ~clk;

   assign tx_dst = rnd_dst ? dst_rnd : dst_fix;

   always @(posedge clk) begin
      #2;
      dst_rnd = 1'($urandom_range(0, 1));
   end

   mvb_split_m_to_n #(
      .INPUTS(IN),
      .OUTPUTS(OUT),
      .DATA_WIDTH(DW)
   ) dut (
      .CLK(clk),
      .RESET_N(rst_n),
      .RX_DATA(rx_data),
      .RX_VLD(rx_vld),
      .RX_SRC_RDY(rx_src),
      .RX_DST_RDY(rx_dst),
      .TX_DATA(tx_data),
      .TX_VLD(tx_vld),
      .TX_SRC_RDY(tx_src),
      .TX_DST_RDY(tx_dst)
   );

   task automatic check(input string tag,
                        input logic [511:0] got,
                        input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] item(input int id);
      logic [31:0] u;
      u = id;
      return {u[12:0], u, u};
   endfunction

   // monitor: scoreboard, contiguity and stall-hold checks
   logic              prev_stall = 1'b0;
   logic [OUT-1:0]    prev_vld;
   logic [OUT*DW-1:0] prev_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_src", tx_src, 1);
            check("hold_vld", tx_vld, prev_vld);
            check("hold_data", tx_data, prev_data);
         end
         if (tx_src) begin
            check("vld_contig",
                  ((tx_vld & (tx_vld + 1)) == 0) && (tx_vld != 0), 1);
         end else begin
            check("vld_idle", tx_vld, 0);
         end
         if (tx_src && tx_dst) begin
            tx_words++;
            vlog.push_back(tx_vld);
            dlog.push_back(tx_data);
            for (int l = 0; l < OUT; l++) begin
               if (tx_vld[l]) begin
                  if (exp_q.size() == 0) begin
                     check("sb_extra", tx_data[l*DW +: DW], 0);
                     failures++;
                  end else begin
                     check("sb_item", tx_data[l*DW +: DW],
                           exp_q.pop_front());
                  end
               end
            end
         end
         if (rx_src && rx_dst) begin
            for (int l = 0; l < IN; l++) begin
               if (rx_vld[l]) exp_q.push_back(rx_data[l*DW +: DW]);
            end
         end
         prev_stall = tx_src && !tx_dst;
         prev_vld   = tx_vld;
         prev_data  = tx_data;
      end
   end

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic present(input logic [IN-1:0] vld, input int wid);
      rx_vld = vld;
      rx_src = 1'b1;
      for (int l = 0; l < IN; l++) begin
         rx_data[l*DW +: DW] = item(wid * IN + l);
      end
   endtask

   task automatic wait_acc(output int waits);
      waits = 0;
      @(negedge clk);
      while (!rx_dst && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!rx_dst) check("acc_timeout", rx_dst, 1);
   endtask

   task automatic send(input logic [IN-1:0] vld, input int wid,
                       output int waits);
      present(vld, wid);
      wait_acc(waits);
      step();
      rx_src = 1'b0;
      rx_vld = IN'($urandom);
   endtask

   task automatic drain;
      int n;
      n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && !tx_src) && n < 300) begin
         n++;
         @(negedge clk);
      end
      check("drain_idle", {exp_q.size() == 0, tx_src}, 2'b10);
   endtask

   function automatic logic [DW-1:0] lane(input logic [OUT*DW-1:0] d,
                                          input int l);
      return d[l*DW +: DW];
   endfunction

   initial begin
      int w;
      int v0;
      int n0;
      int low;
      logic [OUT*DW-1:0] d;
      int l3 [4] = '{0, 5, 10, 15};
      logic [IN-1:0] t6v [8] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F,
                                 16'h0009, 16'h8421, 16'h8000, 16'h00F0};
      logic [OUT-1:0] t6e [8] = '{4'h1, 4'h3, 4'h7, 4'hF,
                                  4'h3, 4'hF, 4'h1, 4'hF};
      logic [IN-1:0] v;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_src", tx_src, 0);
      check("rst_vld", tx_vld, 0);
      check("rst_rxrdy", rx_dst, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_rxrdy", rx_dst, 1);
      check("rel_src", tx_src, 0);

      // 1: reset while draining 12 items
      step();
      dst_fix = 1'b0;
      present(16'h0FFF, 1);
      wait_acc(w);
      step();
      rx_src = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t1_drain_blk", rx_dst, 0);
      check("t1_stall_src", tx_src, 1);
      check("t1_stall_vld", tx_vld, 4'hF);
      step();
      rst_n = 1'b0;
      #1;
      check("t1_rst_src", tx_src, 0);
      check("t1_rst_vld", tx_vld, 0);
      check("t1_rst_rxrdy", rx_dst, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("t1_rst_src2", tx_src, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("t1_rel_rxrdy", rx_dst, 1);
      check("t1_rel_src", tx_src, 0);
      dst_fix = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_no_stale", tx_src, 0);
      end

      // 2: full word drains as four TX words
      step();
      v0 = vlog.size();
      present(16'hFFFF, 2);
      wait_acc(w);
      check("t2_acc_wait", w, 0);
      step();
      rx_src = 1'b0;
      low = 0;
      @(negedge clk);
      while (!rx_dst && low < 20) begin
         low++;
         @(negedge clk);
      end
      check("t2_rx_low", low, 3);
      drain();
      check("t2_words", vlog.size() - v0, 4);
      for (int k = 0; k < 4; k++) begin
         d = dlog[v0 + k];
         check("t2_vld", vlog[v0 + k], 4'hF);
         check("t2_l0", lane(d, 0), item(2 * IN + 4 * k));
         check("t2_l3", lane(d, 3), item(2 * IN + 4 * k + 3));
      end

      // 3: sparse lanes pack to the bottom
      step();
      v0 = vlog.size();
      send(16'h8421, 3, w);
      send(16'h0006, 4, w);
      drain();
      check("t3_words", vlog.size() - v0, 2);
      check("t3_vld0", vlog[v0], 4'hF);
      d = dlog[v0];
      for (int k = 0; k < 4; k++) begin
         check("t3_w0", lane(d, k), item(3 * IN + l3[k]));
      end
      check("t3_vld1", vlog[v0 + 1], 4'h3);
      d = dlog[v0 + 1];
      check("t3_w1l0", lane(d, 0), item(4 * IN + 1));
      check("t3_w1l1", lane(d, 1), item(4 * IN + 2));

      // 4: empty word is swallowed
      step();
      v0 = vlog.size();
      n0 = tx_words;
      send(16'h0000, 5, w);
      check("t4_acc1", w, 0);
      repeat (4) @(negedge clk);
      check("t4_no_tx", tx_words - n0, 0);
      step();
      send(16'h0100, 6, w);
      drain();
      check("t4_words", vlog.size() - v0, 1);
      check("t4_vld", vlog[v0], 4'h1);
      d = dlog[v0];
      check("t4_l0", lane(d, 0), item(6 * IN + 8));

      // 6: back-to-back small words at full rate
      step();
      v0 = vlog.size();
      for (int k = 0; k < 8; k++) begin
         present(t6v[k], 10 + k);
         @(negedge clk);
         check("t6_rxrdy", rx_dst, 1);
         check("t6_tx", tx_src, k >= 2);
         step();
      end
      rx_src = 1'b0;
      @(negedge clk);
      check("t6_tail6", tx_src, 1);
      step();
      @(negedge clk);
      check("t6_tail7", tx_src, 1);
      drain();
      check("t6_words", vlog.size() - v0, 8);
      for (int k = 0; k < 8; k++) begin
         check("t6_vld", vlog[v0 + k], t6e[k]);
      end

      // 5: random stream with random TX back-pressure
      step();
      rnd_dst = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            rx_vld = IN'($urandom);
            repeat ($urandom_range(1, 2)) step();
         end
         if ($urandom_range(0, 1) == 1) v = IN'($urandom);
         else v = IN'($urandom & $urandom);
         send(v, 100 + n, w);
      end
      rnd_dst = 1'b0;
      drain();
      check("t5_sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
